quad_gen: RTL
=============

# quad_gen

Quadrature signal generator: drives A/B outputs that step a commanded number of counts toward a target position, on a circle of CPR counts. It is the transmit-side counterpart of the team's quadrature encoder decoder. Used as a motor/encoder emulator in loopback rigs and as a stimulus source for decoder hardware tests. Emits exactly one A or B edge per count.

## Interface
- CPR, 4000: counts (edges) per revolution; position range 0..CPR-1.
- POS_W, 12: width of position/target; must satisfy 2^POS_W ≥ CPR.
- PER_W, 16: width of the step-period field.

- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle and able to accept; reset 0 while reset_n low, 1 after.
- cmd_target  in  POS_W  target position.
- cmd_period  in  PER_W  clocks between successive edges; 0 treated as 1.
- abort  in  1  stop motion at the current position.
- A, B  out  1  quadrature outputs, registered; reset 0/0.
- position  out  POS_W  current count; reset 0.
- dir  out  1  1 = forward (incrementing), 0 = reverse; reset 1.
- busy  out  1  motion in progress; reset 0.
- done  out  1  one-cycle pulse on completion; reset 0.
- err  out  1  one-cycle pulse on rejected command; reset 0.
- Z  out  1  index; present only with QUAD_GEN_INDEX_EN.

## Operation
- Phase sequence (A,B), forward: 00→01→11→10→00; reverse is the exact inverse. Phase is derived from position[1:0] only (0→00, 1→01, 2→11, 3→10), so A/B and position can never disagree. CPR must be a multiple of 4.
- States: IDLE, RUN.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready (accept cycle T), latch target and period.
  - target ≥ CPR: err pulses at T+1, no motion, stay IDLE.
  - target == position: done pulses at T+1, no edges, stay IDLE.
  - Otherwise go RUN, busy=1 from T+1.
- Direction: df = (target − position) mod CPR. Forward if df ≤ CPR/2, else reverse. The tie at CPR/2 is forward. dir updates at T+1 and holds until the next accepted move.
- RUN: a period timer loads max(P,1) and counts down. At expiry, position steps by ±1 and the timer reloads.
  - Forward wrap: CPR−1→0. Reverse wrap: 0→CPR−1.
- Completion: on the step where the new position equals target, done pulses and the state returns to IDLE in the same cycle.
- abort in RUN: the next clock returns to IDLE with no further edges, done=0, position held. abort in IDLE is ignored. If abort and a step expiry fall in the same cycle, abort wins and the step is suppressed.
- cmd_valid while busy is ignored (cmd_ready=0). Commands are not queued.
- reset_n low mid-move: everything returns to reset values immediately, with A/B=00.

## Timing
- First edge on A/B at T+P. Subsequent edges every P cycles; the last edge is at T+N·P for N steps.
- done is coincident with the final edge. busy=0 and cmd_ready=1 in that same cycle, so a new command can be accepted then.
- With P=1, one edge per clock. The bench's decoder requires P ≥ 2.
- position, A, B and Z all change on the same clock edge.

## Configuration
- QUAD_GEN_INDEX_EN defined:
  - Z port exists. Z=1 exactly while position==0 and 0 otherwise; reset value is 1.
  - Z is registered alongside A/B.
- QUAD_GEN_INDEX_EN undefined: no Z port and no index logic.

## Structure
- Shared package quad_pkg holds:
  - CPR default.
  - State enum (IDLE, RUN).
  - Phase lookup constants (position[1:0] → AB), so the decoder and generator use one definition.
- One sub-module, quad_step_timer: loadable down-counter with a terminal-count strobe, a reload input and a clear input. Direction, position, FSM and handshake stay in quad_gen.

## Test plan
- Reset: hold reset_n low mid-move → A=B=0, position=0, busy=0, done=0, dir=1; cmd_ready=1 on the first clock after release.
- Forward move: position 0, target 3, P=4, accept at T → AB=01@T+4, 11@T+8, 10@T+12. position=3, done at T+12 only, busy low at T+12.
- Reverse wrap: position 1, target 3998, P=2 → dir=0. Positions 0, 3999, 3998 at T+2, T+4, T+6, with AB=00, 10, 11. done at T+6.
- Tie and degenerate cases:
  - Position 0, target 2000, P=1 → dir=1, 2000 consecutive one-cycle edges.
  - Target equal to position → done at T+1, no edges.
  - Target 4000 → err at T+1, no edges, state unchanged.
- Abort: position 0, target 100, P=3, abort at T+10 → last edge at T+9 (position 3). No edges afterwards, done never asserts, cmd_ready=1 at T+11.
- Index (macro on): position 2, target 3998, P=2 → Z=1 only in cycles T+4..T+5 (position 0). Macro off: the design builds without a Z port.

Source files
------------

// File: rtl/quad_pkg.sv
// quad_pkg: shared CPR default, FSM state type and A/B phase table for quadrature generator and decoder
package quad_pkg;
  localparam int CPR_DEF = 4000;
  typedef enum logic {IDLE, RUN} state_t;
  // AB pairs for position[1:0] = 3,2,1,0 (10, 11, 01, 00)
  localparam logic [7:0] PHASE_LUT = 8'b10_11_01_00;
  function automatic logic [1:0] phase_ab(input logic [1:0] p);
    return PHASE_LUT[{p, 1'b0} +: 2];
  endfunction
endpackage

// File: rtl/quad_gen_if.sv
// quad_gen_if: command handshake channel (target position and step period) into quad_gen
interface quad_gen_if #(
  parameter int POS_W = 12,
  parameter int PER_W = 16
);
  logic             valid;
  logic             ready;
  logic [POS_W-1:0] target;
  logic [PER_W-1:0] period;
  modport master(output valid, target, period, input ready);
  modport slave(input valid, target, period, output ready);
endinterface

// File: rtl/quad_step_timer.sv
// quad_step_timer: loadable down-counter whose terminal count (value 1) paces quadrature steps
module quad_step_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic         reload,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] period,
  output logic         tc
);
  logic [W-1:0] cnt;
  assign tc = cnt == W'(1);
  // clear beats load beats reload; otherwise count down and rest at zero
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= clear ? '0 : load ? load_val : reload ? period : cnt == '0 ? cnt : cnt - 1'b1;
endmodule

// File: rtl/quad_gen.sv
// quad_gen: quadrature A/B generator stepping toward a target on a CPR circle; index output Z with QUAD_GEN_INDEX_EN
module quad_gen import quad_pkg::*; #(
  parameter int CPR   = CPR_DEF,
  parameter int POS_W = 12,
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  quad_gen_if.slave        cmd,
  input  logic             abort,
  output logic             A,
  output logic             B,
  output logic [POS_W-1:0] position,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef QUAD_GEN_INDEX_EN
  ,
  output logic             Z
`endif
);
  localparam logic [POS_W-1:0] LAST = POS_W'(CPR - 1);
  state_t state, state_nx;
  logic [POS_W-1:0] tgt, pos_nx, end_tgt;
  logic [PER_W-1:0] per, p1, load_val;
  logic [31:0] df;
  logic accept, bad, same, go, fwd, step_dir, step, arrive, tc;
  // Command decode, shortest-way direction and next position; a period of 1 steps on the accept edge itself
  always_comb begin
    p1 = cmd.period == '0 ? PER_W'(1) : cmd.period;
    load_val = p1 == PER_W'(1) ? PER_W'(1) : p1 - 1'b1;
    accept = cmd.valid & cmd.ready;
    bad = 32'(cmd.target) >= 32'(CPR);
    same = cmd.target == position;
    go = accept & ~bad & ~same;
    df = cmd.target >= position ? 32'(cmd.target) - 32'(position) : 32'(cmd.target) + 32'(CPR) - 32'(position);
    fwd = df <= 32'(CPR / 2);
    step_dir = state == IDLE ? fwd : dir;
    step = state == IDLE ? go & (p1 == PER_W'(1)) : tc & ~abort;
    pos_nx = !step ? position : step_dir ? (position == LAST ? '0 : position + 1'b1) : (position == '0 ? LAST : position - 1'b1);
    end_tgt = state == IDLE ? cmd.target : tgt;
    arrive = step & (pos_nx == end_tgt);
    state_nx = state == IDLE ? (go & ~arrive ? RUN : IDLE) : (abort | arrive ? IDLE : RUN);
  end
  quad_step_timer #(.W(PER_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state_nx == IDLE),
    .load     (go),
    .reload   (tc),
    .load_val (load_val),
    .period   (per),
    .tc       (tc)
  );
  // FSM, position and all outputs update on one edge so A/B/Z can never disagree with position
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      position <= '0;
      {A, B} <= 2'b00;
      dir <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      cmd.ready <= 1'b0;
      tgt <= '0;
      per <= PER_W'(1);
`ifdef QUAD_GEN_INDEX_EN
      Z <= 1'b1;
`endif
    end else begin
      state <= state_nx;
      position <= pos_nx;
      {A, B} <= phase_ab(pos_nx[1:0]);
      busy <= state_nx == RUN;
      cmd.ready <= state_nx == IDLE;
      done <= (accept & same) | arrive;
      err <= accept & bad;
`ifdef QUAD_GEN_INDEX_EN
      Z <= pos_nx == '0;
`endif
      if (go) begin
        tgt <= cmd.target;
        per <= p1;
        dir <= fwd;
      end
    end
endmodule
